uart_alu_ctrl: RTL and testbench

//  Command sequencer sitting directly downstream of uart_interface: it pops RX-FIFO bytes and parses

---
 rtl/uart_alu_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Command sequencer between a UART's RX/TX FIFOs and a combinational ALU.
// Parses [opcode, A, B] frames and returns one result byte, or ERR_CODE on bad opcode/timeout.
module uart_alu_ctrl #(
  parameter int unsigned         NB_DATA    = 8,
  parameter int unsigned         NB_OP      = 6,
  parameter logic [NB_DATA-1:0]  ERR_CODE   = 8'hEE,
  parameter int unsigned         TIMEOUT    = 50_000_000,
  parameter int unsigned         NB_TIMEOUT = 26
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_read_uart,
  input  logic               i_tx_full,
  output logic               o_write_uart,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy
);

  localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'h27);
  localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'h03);
  localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'h02);

  localparam logic [NB_TIMEOUT-1:0] TmoLast = NB_TIMEOUT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StExec,
    StSend,
    StErr
  } state_e;

  state_e                 state_q;
  logic                   pop_gap_q;
  logic [NB_TIMEOUT-1:0]  tmo_q;
  logic [NB_DATA-1:0]     data_a_q;
  logic [NB_DATA-1:0]     data_b_q;
  logic [NB_DATA-1:0]     tx_data_q;
  logic [NB_OP-1:0]       op_q;

  logic rx_state;
  logic pop;
  logic push;
  logic op_valid;
  logic tmo_hit;

  function automatic logic is_valid_op(input logic [NB_DATA-1:0] b);
    logic ok;
    ok = (b[NB_DATA-1:NB_OP] == '0);
    if (!(b[NB_OP-1:0] inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl})) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Strobes are combinational so the pop/push lands in the same cycle as the capture/state change;
  // pop_gap_q blocks a pop in the cycle right after one, giving the FIFO a cycle to advance.
  always_comb begin
    rx_state = (state_q == StIdle) || (state_q == StGetA) || (state_q == StGetB);
    pop      = rx_state && !i_rx_empty && !pop_gap_q && !i_reset;
    push     = ((state_q == StSend) || (state_q == StErr)) && !i_tx_full && !i_reset;
    op_valid = is_valid_op(i_rx_data);
    tmo_hit  = (tmo_q == TmoLast);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      pop_gap_q <= 1'b0;
      tmo_q     <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      tx_data_q <= '0;
      op_q      <= '0;
    end else begin
      pop_gap_q <= pop;
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (pop) begin
            if (op_valid) begin
              op_q    <= i_rx_data[NB_OP-1:0];
              state_q <= StGetA;
            end else begin
              tx_data_q <= ERR_CODE;
              state_q   <= StErr;
            end
          end
        end
        StGetA, StGetB: begin
          // A pop in the same cycle as the timeout wins.
          if (pop) begin
            tmo_q <= '0;
            if (state_q == StGetA) begin
              data_a_q <= i_rx_data;
              state_q  <= StGetB;
            end else begin
              data_b_q <= i_rx_data;
              state_q  <= StExec;
            end
          end else if (tmo_hit) begin
            tmo_q     <= '0;
            tx_data_q <= ERR_CODE;
            state_q   <= StErr;
          end else begin
            tmo_q <= tmo_q + NB_TIMEOUT'(1);
          end
        end
        StExec: begin
          tx_data_q <= i_alu_result;
          state_q   <= StSend;
        end
        StSend, StErr: begin
          tmo_q <= '0;
          if (push) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_read_uart  = pop;
  assign o_write_uart = push;
  assign o_tx_data    = tx_data_q;
  assign o_data_a     = data_a_q;
  assign o_data_b     = data_b_q;
  assign o_op         = op_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: queue-based RX/TX FIFO models, behavioural ALU, directed + random frames.
module tb_uart_alu_ctrl;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       read_uart;
  logic       tx_full;
  logic       write_uart;
  logic [7:0] tx_data;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [5:0] op;
  logic [7:0] alu_result;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop = -10;
  int n_pops = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA   (8),
    .NB_OP     (6),
    .ERR_CODE  (8'hEE),
    .TIMEOUT   (TMO),
    .NB_TIMEOUT(26)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_empty  (rx_empty),
    .i_rx_data   (rx_data),
    .o_read_uart (read_uart),
    .i_tx_full   (tx_full),
    .o_write_uart(write_uart),
    .o_tx_data   (tx_data),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op        (op),
    .i_alu_result(alu_result),
    .o_busy      (busy)
  );

  function automatic logic [7:0] ref_alu(input logic [5:0] o, input logic [7:0] a,
                                         input logic [7:0] b);
    case (o)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = ref_alu(op, data_a, data_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO models: pops/pushes happen on the rising edge, flags refresh on the falling edge.
  always @(posedge clk) begin
    cyc++;
    if (read_uart) begin
      chk("pop_nonempty", {31'b0, rx_empty}, 0);
      chk("pop_spacing", {31'b0, (cyc - last_pop) >= 2}, 1);
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      last_pop = cyc;
      n_pops++;
    end
    if (write_uart) begin
      chk("push_txfree", {31'b0, tx_full}, 0);
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_push(input string tag, input logic [7:0] exp, output int pc);
    int t;
    t = 0;
    pc = -1;
    while (tx_log.size() == 0 && t < 200) begin
      tick(1);
      t++;
    end
    chk({tag, "_count"}, tx_log.size(), 1);
    if (tx_log.size() > 0) begin
      pc = tx_cyc.pop_front();
      chk({tag, "_byte"}, {24'b0, tx_log.pop_front()}, {24'b0, exp});
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp);
    int pc;
    rx_q.push_back(o);
    rx_q.push_back(a);
    rx_q.push_back(b);
    wait_push(tag, exp, pc);
    chk({tag, "_op"}, {26'b0, op}, {24'b0, o});
    chk({tag, "_a"}, {24'b0, data_a}, {24'b0, a});
    chk({tag, "_b"}, {24'b0, data_b}, {24'b0, b});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, {31'b0, read_uart}, 0);
    chk({tag, "_write"}, {31'b0, write_uart}, 0);
    chk({tag, "_txdata"}, {24'b0, tx_data}, 0);
    chk({tag, "_a"}, {24'b0, data_a}, 0);
    chk({tag, "_b"}, {24'b0, data_b}, 0);
    chk({tag, "_op"}, {26'b0, op}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int c;
    int t;
    int np0;
    logic [7:0] ops[8];
    logic [7:0] m_op, m_a, m_b, ro, ra, rb;

    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    rst = 1'b0;
    tx_full = 1'b0;
    rx_empty = 1'b1;
    rx_data = 8'h00;
    #1 rst = 1'b1;
    tick(3);
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    tick(2);

    // Basic ADD with latency check from the B pop to the push.
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h05);
    rx_q.push_back(8'h03);
    wait_push("add", 8'h08, pc);
    chk("add_latency", pc - last_pop, 2);
    chk("add_op", {26'b0, op}, 32'h20);
    chk("add_a", {24'b0, data_a}, 32'h05);
    chk("add_b", {24'b0, data_b}, 32'h03);
    tick(2);
    chk("add_idle", {31'b0, busy}, 0);

    frame("sub", 8'h22, 8'h03, 8'h05, 8'hFE);
    frame("sra", 8'h03, 8'hF0, 8'h02, 8'hFC);
    frame("srl", 8'h02, 8'hF0, 8'h02, 8'h3C);

    // Bad opcodes: one error byte each, operand registers untouched.
    rx_q.push_back(8'h3F);
    wait_push("err3f", 8'hEE, pc);
    rx_q.push_back(8'h60);
    wait_push("err60", 8'hEE, pc);
    tick(5);
    chk("err_single", tx_log.size(), 0);
    chk("err_idle", {31'b0, busy}, 0);
    chk("err_op", {26'b0, op}, 32'h02);
    chk("err_a", {24'b0, data_a}, 32'hF0);
    chk("err_b", {24'b0, data_b}, 32'h02);

    // Timeout after a partial frame, then a clean frame.
    rx_q.push_back(8'h24);
    rx_q.push_back(8'hAA);
    wait_push("tmo", 8'hEE, pc);
    chk("tmo_window", {31'b0, (pc - last_pop >= int'(TMO) - 1) && (pc - last_pop <= int'(TMO) + 2)},
        1);
    chk("tmo_b_kept", {24'b0, data_b}, 32'h02);
    tick(2);
    frame("or", 8'h25, 8'h0F, 8'hF0, 8'hFF);

    // TX back-pressure.
    @(negedge clk) tx_full = 1'b1;
    rx_q.push_back(8'h26);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h0F);
    tick(30);
    chk("txfull_nopush", tx_log.size(), 0);
    chk("txfull_busy", {31'b0, busy}, 1);
    chk("txfull_write", {31'b0, write_uart}, 0);
    @(negedge clk);
    tx_full = 1'b0;
    c = cyc;
    wait_push("txfull", 8'hF0, pc);
    chk("txfull_latency", pc, c + 1);

    // Reset in the middle of a frame.
    tick(2);
    np0 = n_pops;
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h11);
    t = 0;
    while (n_pops < np0 + 2 && t < 50) begin
      tick(1);
      t++;
    end
    chk("midrst_pops", n_pops - np0, 2);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    chk("midrst_nopush", tx_log.size(), 0);
    @(negedge clk) rst = 1'b0;
    tick(2);
    frame("postrst", 8'h20, 8'h01, 8'h01, 8'h02);

    // Random frames against the reference model.
    m_op = 8'h20;
    m_a = 8'h01;
    m_b = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick(1 + $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        ro = 8'($urandom_range(8'h28, 8'hFF));
        rx_q.push_back(ro);
        wait_push("rnd_err", 8'hEE, pc);
      end else begin
        ro = ops[$urandom_range(0, 7)];
        ra = 8'($urandom);
        rb = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk) tx_full = 1'b1;
          rx_q.push_back(ro);
          rx_q.push_back(ra);
          rx_q.push_back(rb);
          tick($urandom_range(10, 25));
          chk("rnd_hold", tx_log.size(), 0);
          @(negedge clk) tx_full = 1'b0;
        end else begin
          rx_q.push_back(ro);
          tick($urandom_range(0, 6));
          rx_q.push_back(ra);
          tick($urandom_range(0, 6));
          rx_q.push_back(rb);
        end
        m_op = ro;
        m_a = ra;
        m_b = rb;
        wait_push("rnd", ref_alu(ro[5:0], ra, rb), pc);
      end
      chk("rnd_op", {26'b0, op}, {24'b0, m_op});
      chk("rnd_a", {24'b0, data_a}, {24'b0, m_a});
      chk("rnd_b", {24'b0, data_b}, {24'b0, m_b});
    end

    tick(5);
    chk("final_idle", {31'b0, busy}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
